// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and helpers for the sequential command ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  // Divide/mod by zero defaults to an all-ones result of whatever width the top uses.
  localparam bit DIV0_ALL_ONES = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide-by-zero resolves in one cycle, so it never needs the iterative unit.
  function automatic logic needs_iter(input logic [2:0] opc, input logic b_zero);
    return (opc == OP_MUL) || (((opc == OP_DIV) || (opc == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: shift-add multiply or restoring divide, one step per cycle over OP_W cycles.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic              o_done,
  output logic [2*OP_W-1:0] o_product,
  output logic [OP_W-1:0]   o_quotient,
  output logic [OP_W-1:0]   o_remainder
);

  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = (OP_W > 2) ? $clog2(OP_W) : 1;

  logic             r_busy;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_prod;
  logic [RES_W-1:0] r_mcand;
  logic [OP_W-1:0]  r_mplier;
  logic [OP_W-1:0]  r_q;
  logic [OP_W-1:0]  r_rem;
  logic [OP_W-1:0]  r_b;

  logic [RES_W-1:0] w_prod_nxt;
  logic [OP_W:0]    w_shift;
  logic [OP_W:0]    w_diff;
  logic             w_ge;
  logic [OP_W-1:0]  w_q_nxt;
  logic [OP_W-1:0]  w_rem_nxt;

  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_shift    = {r_rem, r_q[OP_W-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_ge       = ~w_diff[OP_W];
  assign w_q_nxt    = {r_q[OP_W-2:0], w_ge};
  assign w_rem_nxt  = w_ge ? w_diff[OP_W-1:0] : w_shift[OP_W-1:0];

  // Results are the post-final-step values so the top can register them on the done edge.
  assign o_done      = r_busy && (r_cnt == '0);
  assign o_product   = w_prod_nxt;
  assign o_quotient  = w_q_nxt;
  assign o_remainder = w_rem_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_mode   <= MD_MUL;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_mode   <= i_mode;
      r_cnt    <= CNT_W'(OP_W - 1);
      r_prod   <= '0;
      r_mcand  <= RES_W'(i_a);
      r_mplier <= i_b;
      r_q      <= i_a;
      r_rem    <= '0;
      r_b      <= i_b;
    end else if (r_busy) begin
      if (r_mode == MD_MUL) begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else begin
        r_q   <= w_q_nxt;
        r_rem <= w_rem_nxt;
      end
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle command ALU: FSM, single-cycle datapath, flags and both handshakes.
module seq_alu
  import alu_pkg::*;
#(
  parameter int                    OP_W     = 4,
  parameter logic [2*OP_W-1:0]     DIV0_VAL = {(2*OP_W){DIV0_ALL_ONES}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        opcode,
  input  logic [OP_W-1:0]   op1,
  input  logic [OP_W-1:0]   op2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*OP_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_neg,
  output logic              flag_div0,
  output logic              busy
);

  localparam int RES_W = 2 * OP_W;

  state_t           r_state;
  logic [2:0]       r_opc;

  logic             w_accept;
  logic             w_iter;
  logic             w_start;
  logic             w_done;
  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;
  logic [RES_W-1:0] w_s_res;
  logic             w_s_neg;
  logic             w_s_div0;
  logic [RES_W-1:0] w_prod;
  logic [OP_W-1:0]  w_quo;
  logic [OP_W-1:0]  w_rem;
  logic [RES_W-1:0] w_i_res;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_iter   = needs_iter(opcode, op2 == '0);
  assign w_start  = w_accept && w_iter;
  assign w_a      = RES_W'(op1);
  assign w_b      = RES_W'(op2);

  alu_muldiv_iter #(.OP_W(OP_W)) u_iter (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_mode      ((opcode == OP_MUL) ? MD_MUL : MD_DIV),
    .i_a         (op1),
    .i_b         (op2),
    .o_done      (w_done),
    .o_product   (w_prod),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // DIV/MOD entries here only take effect when op2 is zero; otherwise the iterative path wins.
  always_comb begin
    w_s_res  = '0;
    w_s_neg  = 1'b0;
    w_s_div0 = 1'b0;
    case (opcode)
      OP_ADD: w_s_res = w_a + w_b;
      OP_SUB: begin
        w_s_res = w_a - w_b;
        w_s_neg = (op1 < op2);
      end
      OP_DIV, OP_MOD: begin
        w_s_res  = DIV0_VAL;
        w_s_div0 = 1'b1;
      end
      OP_AND:  w_s_res = w_a & w_b;
      OP_OR:   w_s_res = w_a | w_b;
      OP_XOR:  w_s_res = w_a ^ w_b;
      default: w_s_res = '0;
    endcase
  end

  always_comb begin
    w_i_res = RES_W'(w_rem);
    case (r_opc)
      OP_MUL:  w_i_res = w_prod;
      OP_DIV:  w_i_res = RES_W'(w_quo);
      default: w_i_res = RES_W'(w_rem);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_opc     <= OP_ADD;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      flag_div0 <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opc     <= opcode;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (w_iter) begin
              r_state <= ST_EXEC;
            end else begin
              r_state   <= ST_DONE;
              res_valid <= 1'b1;
              result    <= w_s_res;
              flag_zero <= (w_s_res == '0);
              flag_neg  <= w_s_neg;
              flag_div0 <= w_s_div0;
            end
          end
        end
        ST_EXEC: begin
          if (w_done) begin
            r_state   <= ST_DONE;
            res_valid <= 1'b1;
            result    <= w_i_res;
            flag_zero <= (w_i_res == '0);
            flag_neg  <= 1'b0;
            flag_div0 <= 1'b0;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state   <= ST_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (OP_W = 4): directed commands push expectations, a monitor checks results.
module tb_seq_alu;

  localparam int OP_W = 4;
  localparam int RES_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       opcode = 3'd0;
  logic [OP_W-1:0]  op1 = '0;
  logic [OP_W-1:0]  op2 = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [RES_W-1:0] result;
  logic             flag_zero, flag_neg, flag_div0, busy;

  typedef struct {
    logic [RES_W-1:0] res;
    logic             z, n, d;
    int               lat;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_v = 1'b0;

  seq_alu #(.OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_div0(flag_div0),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising res_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && res_valid && !prev_v) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("flag_zero", int'(flag_zero), int'(e.z));
        chk("flag_neg", int'(flag_neg), int'(e.n));
        chk("flag_div0", int'(flag_div0), int'(e.d));
        chk("latency", cyc - e.acc + 1, e.lat);
      end
    end
    prev_v = res_valid;
  end

  task automatic issue(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] r, input logic z, input logic n, input logic d,
                       input int lat, input bit push);
    exp_t e;
    int   n_wait;
    n_wait = 0;
    @(negedge clk);
    while (!cmd_ready && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    opcode = opc; op1 = a; op2 = b; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (push) begin
      e.res = r; e.z = z; e.n = n; e.d = d; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n_wait;
    n_wait = 0;
    @(negedge clk);
    while ((q.size() != 0 || res_valid || !cmd_ready) && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    if (q.size() != 0 || res_valid || !cmd_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({flag_zero, flag_neg, flag_div0}), 0);
    reset = 1'b1;

    // ADD: latency 1, then ready again the cycle after the handshake
    issue(3'd0, 4'd7, 4'd9, 8'h10, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("add_res_valid", int'(res_valid), 1);
    @(negedge clk);
    chk("add_cmd_ready_back", int'(cmd_ready), 1);
    wait_idle();

    issue(3'd1, 4'd3, 4'd5, 8'hFE, 0, 1, 0, 1, 1);
    wait_idle();
    issue(3'd1, 4'd5, 4'd5, 8'h00, 1, 0, 0, 1, 1);
    wait_idle();

    // MUL with an ignored command pulse during EXEC
    issue(3'd2, 4'd15, 4'd15, 8'hE1, 0, 0, 0, 5, 1);
    @(negedge clk);
    chk("mul_busy", int'(busy), 1);
    chk("mul_cmd_ready", int'(cmd_ready), 0);
    opcode = 3'd0; op1 = 4'd1; op2 = 4'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mul_busy2", int'(busy), 1);
    wait_idle();

    issue(3'd3, 4'd13, 4'd4, 8'h03, 0, 0, 0, 5, 1);
    wait_idle();
    issue(3'd4, 4'd13, 4'd4, 8'h01, 0, 0, 0, 5, 1);
    wait_idle();
    issue(3'd3, 4'd9, 4'd0, 8'hFF, 0, 0, 1, 1, 1);
    wait_idle();
    issue(3'd4, 4'd9, 4'd0, 8'hFF, 0, 0, 1, 1, 1);
    wait_idle();
    issue(3'd5, 4'hC, 4'hA, 8'h08, 0, 0, 0, 1, 1);
    wait_idle();
    issue(3'd6, 4'hC, 4'h3, 8'h0F, 0, 0, 0, 1, 1);
    wait_idle();
    issue(3'd2, 4'd0, 4'd7, 8'h00, 1, 0, 0, 5, 1);
    wait_idle();
    issue(3'd3, 4'd3, 4'd7, 8'h00, 1, 0, 0, 5, 1);
    wait_idle();
    issue(3'd4, 4'd3, 4'd7, 8'h03, 0, 0, 0, 5, 1);
    wait_idle();
    issue(3'd2, 4'd13, 4'd11, 8'h8F, 0, 0, 0, 5, 1);
    wait_idle();

    // Backpressure: result held stable while res_ready is low
    res_ready = 1'b0;
    issue(3'd7, 4'hA, 4'h6, 8'h0C, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_result", int'(result), 8'h0C);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid_drop", int'(res_valid), 0);
    chk("bp_cmd_ready", int'(cmd_ready), 1);
    chk("bp_busy", int'(busy), 0);
    res_ready = 1'b1;

    // Asynchronous reset in the second EXEC cycle of a MUL aborts it
    issue(3'd2, 4'd7, 4'd3, 8'h15, 0, 0, 0, 5, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_flags", int'({flag_zero, flag_neg, flag_div0}), 0);
    chk("arst_cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_res_valid", int'(res_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle command ALU in the UART command processor.
- Accepts a decoded command (opcode plus two operands) from the command parser over a valid/ready handshake.
- Runs add/sub/logic in one cycle and mul/div/mod iteratively over OP_W cycles.
- Holds the result and status flags under a valid/ready handshake, so the UART TX path can back-pressure it.

Parameters:
- OP_W, 4: operand width in bits, legal range 2..16. Result width RES_W = 2*OP_W is a derived localparam, not overridable.
- DIV0_VAL, all-ones: result returned on divide/mod by zero, RES_W bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- opcode  in  3  operation select; see Behaviour
- op1  in  OP_W  operand A, unsigned
- op2  in  OP_W  operand B, unsigned
- res_valid  out  1  result and flags valid
- res_ready  in  1  consumer (TX launcher) takes the result
- result  out  RES_W  operation result
- flag_zero  out  1  result == 0
- flag_neg  out  1  SUB borrow (op1 < op2); 0 for other ops
- flag_div0  out  1  DIV/MOD with op2 == 0
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous, low:
  - state = IDLE, cmd_ready = 1.
  - res_valid, busy and all flags = 0; result = 0.
  - Iteration counter and internal registers cleared.
  - Reset asserted mid-EXEC or mid-DONE aborts the operation; no result is emitted after reset release.
- Opcodes:
  - 0 ADD: op1 + op2.
  - 1 SUB: op1 - op2, modulo 2^RES_W.
  - 2 MUL: unsigned product.
  - 3 DIV: quotient.
  - 4 MOD: remainder.
  - 5 AND, 6 OR, 7 XOR: bitwise, zero-extended to RES_W.
  - All operands are zero-extended to RES_W before arithmetic.
- Accept: on a clk edge with cmd_valid && cmd_ready, latch opcode, op1 and op2. Inputs are not sampled again until the next IDLE.
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> DONE on accepting a single-cycle op (ADD/SUB/logic, or DIV/MOD with op2 == 0). res_valid is high the cycle after the accept edge: latency 1.
  - IDLE -> EXEC on accepting MUL, or DIV/MOD with op2 != 0. The counter loads OP_W-1.
  - EXEC: one shift-add step (MUL) or one restoring-divide step (DIV/MOD) per cycle, counter decrements. On counter == 0 the final step completes and the FSM moves to DONE. res_valid rises exactly OP_W+1 cycles after the accept edge.
  - DONE: res_valid = 1. result and flags are stable until the handshake. On res_valid && res_ready -> IDLE, with res_valid dropping the next cycle.
- No back-to-back overlap: cmd_ready = 0 in EXEC and DONE, so cmd_valid is ignored (not queued). Simultaneous res_ready and cmd_valid in DONE leaves the command waiting until IDLE.
- Flags are registered together with result:
  - flag_zero from the final result.
  - flag_neg set only for SUB.
  - flag_div0 set only for DIV/MOD with op2 == 0; result = DIV0_VAL in that case.
- Divide-by-zero never enters EXEC.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_XOR), FSM state encodings, DIV0 default.
- Sub-module alu_muldiv_iter: iterative shift-add multiplier plus restoring divider.
  - Interface: start, mode (mul/div), a, b, done, product/quotient/remainder.
  - Counter lives inside it.
- seq_alu keeps the FSM, single-cycle datapath, flags and handshakes.

Test Plan (OP_W = 4):
- ADD 7+9 with res_ready = 1 -> res_valid 1 cycle after accept; result 0x10, all flags 0; cmd_ready back to 1 next cycle.
- SUB 3-5 -> result 0xFE, flag_neg = 1, latency 1; SUB 5-5 -> 0x00, flag_zero = 1.
- MUL 15*15 -> result 0xE1 exactly 5 cycles after accept; busy high throughout; a cmd_valid pulse during EXEC is ignored (no second result).
- DIV 13/4 -> 0x03 and MOD 13/4 -> 0x01, each 5-cycle latency; DIV 9/0 -> 0xFF, flag_div0 = 1, latency 1.
- Backpressure: hold res_ready = 0 for 10 cycles after an XOR 0xA^0x6 -> result 0x0C stable with res_valid high; res_ready pulse -> IDLE next cycle.
- Reset asserted asynchronously in EXEC cycle 2 of MUL -> all outputs 0 immediately; after release, state IDLE, no res_valid.
